// File: rtl/can_intermission_monitor.sv
// CAN inter-frame space monitor: bus integration, 3-bit intermission tracking,
// overload request and hard-SOF detection between frame decoder and overload maker.
module can_intermission_monitor #(
    parameter int unsigned INTEG_BITS = 11,
    parameter int unsigned MAX_OVRLD  = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sp,
    input  logic       i_rx,
    input  logic       i_f_eof_n,
    input  logic       i_f_itmss_n,
    output logic       o_f_ovrld_n,
    output logic       o_f_sof_n,
    output logic       o_bus_idle,
    output logic       o_in_itm,
    output logic [1:0] o_ovrld_cnt,
    output logic       o_ovrld_err
);

    typedef enum logic [2:0] {
        StInteg,
        StIdle,
        StFrame,
        StItm,
        StOvl
    } state_e;

    localparam logic [3:0] INTEG_LAST = 4'(INTEG_BITS - 1);
    localparam logic [1:0] MAX_CNT    = 2'(MAX_OVRLD);

    state_e     r_state;
    logic [3:0] r_rec_cnt;
    logic [1:0] r_itm_idx;
    logic       r_ovrld_n;
    logic       r_sof_n;
    logic       r_bus_idle;
    logic       r_in_itm;
    logic [1:0] r_ovrld_cnt;
    logic       r_ovrld_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StInteg;
            r_rec_cnt   <= 4'd0;
            r_itm_idx   <= 2'd0;
            r_ovrld_n   <= 1'b1;
            r_sof_n     <= 1'b1;
            r_bus_idle  <= 1'b0;
            r_in_itm    <= 1'b0;
            r_ovrld_cnt <= 2'd0;
            r_ovrld_err <= 1'b0;
        end else if (i_sp) begin
            // Request pulses last exactly one bit time.
            r_ovrld_n <= 1'b1;
            r_sof_n   <= 1'b1;
            case (r_state)
                StInteg: begin
                    if (!i_rx) begin
                        r_rec_cnt <= 4'd0;
                    end else if (r_rec_cnt == INTEG_LAST) begin
                        r_rec_cnt  <= 4'd0;
                        r_bus_idle <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + 4'd1;
                    end
                end
                StIdle: begin
                    if (!i_rx) begin
                        r_sof_n     <= 1'b0;
                        r_bus_idle  <= 1'b0;
                        r_ovrld_cnt <= 2'd0;
                        r_state     <= StFrame;
                    end
                end
                StFrame: begin
                    if (!i_f_eof_n || !i_f_itmss_n) begin
                        r_itm_idx <= 2'd1;
                        r_in_itm  <= 1'b1;
                        r_state   <= StItm;
                    end
                end
                StItm: begin
                    if (r_itm_idx == 2'd3) begin
                        r_in_itm <= 1'b0;
                        if (!i_rx) begin
                            r_sof_n     <= 1'b0;
                            r_ovrld_cnt <= 2'd0;
                            r_state     <= StFrame;
                        end else begin
                            r_bus_idle <= 1'b1;
                            r_state    <= StIdle;
                        end
                    end else if (!i_rx) begin
                        r_in_itm <= 1'b0;
                        if (r_ovrld_cnt < MAX_CNT) begin
                            r_ovrld_n <= 1'b0;
                            if (r_ovrld_cnt != 2'd3) begin
                                r_ovrld_cnt <= r_ovrld_cnt + 2'd1;
                            end
                            r_state <= StOvl;
                        end else begin
                            // Too many back-to-back overloads: re-integrate.
                            r_ovrld_err <= 1'b1;
                            r_rec_cnt   <= 4'd0;
                            r_state     <= StInteg;
                        end
                    end else begin
                        r_itm_idx <= r_itm_idx + 2'd1;
                    end
                end
                StOvl: begin
                    if (!i_f_itmss_n) begin
                        r_itm_idx <= 2'd1;
                        r_in_itm  <= 1'b1;
                        r_state   <= StItm;
                    end
                end
                default: begin
                    r_state <= StInteg;
                end
            endcase
        end
    end

    assign o_f_ovrld_n = r_ovrld_n;
    assign o_f_sof_n   = r_sof_n;
    assign o_bus_idle  = r_bus_idle;
    assign o_in_itm    = r_in_itm;
    assign o_ovrld_cnt = r_ovrld_cnt;
    assign o_ovrld_err = r_ovrld_err;

endmodule

// File: tb/tb_can_intermission_monitor.sv
// Directed bench for can_intermission_monitor: one sp every 4 clocks, outputs
// sampled on the negedge well after the sp edge.
module tb_can_intermission_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sp = 1'b0;
    logic       rx = 1'b1;
    logic       f_eof_n = 1'b1;
    logic       f_itmss_n = 1'b1;
    logic       f_ovrld_n;
    logic       f_sof_n;
    logic       bus_idle;
    logic       in_itm;
    logic [1:0] ovrld_cnt;
    logic       ovrld_err;

    int n_tests = 0;
    int n_fail  = 0;

    can_intermission_monitor #(
        .INTEG_BITS(11),
        .MAX_OVRLD (2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_sp       (sp),
        .i_rx       (rx),
        .i_f_eof_n  (f_eof_n),
        .i_f_itmss_n(f_itmss_n),
        .o_f_ovrld_n(f_ovrld_n),
        .o_f_sof_n  (f_sof_n),
        .o_bus_idle (bus_idle),
        .o_in_itm   (in_itm),
        .o_ovrld_cnt(ovrld_cnt),
        .o_ovrld_err(ovrld_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One bit time: sp high for one clk, then three idle clks; returns on a negedge.
    task automatic send_bit(input logic b_rx, input logic b_eof_n, input logic b_itmss_n);
        @(negedge clk);
        rx        = b_rx;
        f_eof_n   = b_eof_n;
        f_itmss_n = b_itmss_n;
        sp        = 1'b1;
        @(negedge clk);
        sp        = 1'b0;
        f_eof_n   = 1'b1;
        f_itmss_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic recessive(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b1, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ovrld_n"}, int'(f_ovrld_n), 1);
        check({tag, "_sof_n"}, int'(f_sof_n), 1);
        check({tag, "_bus_idle"}, int'(bus_idle), 0);
        check({tag, "_in_itm"}, int'(in_itm), 0);
        check({tag, "_ovrld_cnt"}, int'(ovrld_cnt), 0);
        check({tag, "_ovrld_err"}, int'(ovrld_err), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Integration, restarted by a dominant bit.
        recessive(5);
        send_bit(1'b0, 1'b1, 1'b1);
        recessive(10);
        check("integ_10", int'(bus_idle), 0);
        recessive(1);
        check("integ_11", int'(bus_idle), 1);

        // SOF from idle, EOF, clean intermission back to idle.
        send_bit(1'b0, 1'b1, 1'b1);
        check("sof_pulse", int'(f_sof_n), 0);
        check("sof_idle", int'(bus_idle), 0);
        send_bit(1'b1, 1'b1, 1'b1);
        check("sof_release", int'(f_sof_n), 1);
        send_bit(1'b1, 1'b0, 1'b1);
        check("eof_in_itm", int'(in_itm), 1);
        recessive(1);
        check("itm1_in_itm", int'(in_itm), 1);
        recessive(1);
        check("itm2_in_itm", int'(in_itm), 1);
        check("itm2_idle", int'(bus_idle), 0);
        recessive(1);
        check("itm3_in_itm", int'(in_itm), 0);
        check("itm3_idle", int'(bus_idle), 1);

        // Overload at intermission bit 2, delimiter, then idle.
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        recessive(1);
        send_bit(1'b0, 1'b1, 1'b1);
        check("ovl2_req", int'(f_ovrld_n), 0);
        check("ovl2_cnt", int'(ovrld_cnt), 1);
        check("ovl2_in_itm", int'(in_itm), 0);
        send_bit(1'b0, 1'b1, 1'b1);
        check("ovl2_release", int'(f_ovrld_n), 1);
        send_bit(1'b1, 1'b1, 1'b0);
        check("ovl2_itmss", int'(in_itm), 1);
        recessive(3);
        check("ovl2_idle", int'(bus_idle), 1);
        check("ovl2_cnt_keep", int'(ovrld_cnt), 1);

        // SOF clears the overload count; dominant at bit 3 is a hard SOF.
        send_bit(1'b0, 1'b1, 1'b1);
        check("sof_cnt_clr", int'(ovrld_cnt), 0);
        send_bit(1'b1, 1'b0, 1'b1);
        recessive(2);
        send_bit(1'b0, 1'b1, 1'b1);
        check("hsof_sof", int'(f_sof_n), 0);
        check("hsof_ovrld", int'(f_ovrld_n), 1);
        check("hsof_cnt", int'(ovrld_cnt), 0);
        check("hsof_in_itm", int'(in_itm), 0);
        check("hsof_idle", int'(bus_idle), 0);

        // Three overloads at bit 1: third one is an error and forces integration.
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        check("ovr_a_req", int'(f_ovrld_n), 0);
        check("ovr_a_cnt", int'(ovrld_cnt), 1);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1);
        check("ovr_b_req", int'(f_ovrld_n), 0);
        check("ovr_b_cnt", int'(ovrld_cnt), 2);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1);
        check("ovr_c_req", int'(f_ovrld_n), 1);
        check("ovr_c_err", int'(ovrld_err), 1);
        check("ovr_c_in_itm", int'(in_itm), 0);
        recessive(10);
        check("ovr_integ_10", int'(bus_idle), 0);
        recessive(1);
        check("ovr_integ_11", int'(bus_idle), 1);
        check("ovr_err_sticky", int'(ovrld_err), 1);

        // Reset during OVL.
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        check("pre_rst_ovl", int'(f_ovrld_n), 0);
        reset = 1'b1;
        #1;
        check_reset_values("rst_ovl");
        @(negedge clk);
        reset = 1'b0;
        send_bit(1'b0, 1'b1, 1'b1);
        check("rst_ovl_no_sof", int'(f_sof_n), 1);
        recessive(10);
        check("rst_ovl_integ_10", int'(bus_idle), 0);
        recessive(1);
        check("rst_ovl_integ_11", int'(bus_idle), 1);

        // Reset during intermission bit 2 (entered via the delimiter strobe).
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        check("itmss_in_itm", int'(in_itm), 1);
        recessive(1);
        reset = 1'b1;
        #1;
        check_reset_values("rst_itm");
        @(negedge clk);
        reset = 1'b0;
        send_bit(1'b0, 1'b1, 1'b1);
        check("rst_itm_no_sof", int'(f_sof_n), 1);
        check("rst_itm_no_ovl", int'(f_ovrld_n), 1);
        check("rst_itm_idle", int'(bus_idle), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
